// File: rtl/debounce_pkg.sv
// Shared debounce definitions: FSM state encoding for single- and multi-button front-ends.
package debounce_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    IDLE         = ST_IDLE,
    PRESS_WAIT   = ST_PRESS_WAIT,
    HELD         = ST_HELD,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      q     <= 1'b0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: synchronizes a bouncing level, debounces it and emits
// one single-cycle pulse per accepted press for the downstream counter enable.
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level_out,
  output logic pulse_out,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  // cnt counts stable cycles after the first one that moved us out of IDLE/HELD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= HELD;
            level_out <= 1'b1;
            pulse_out <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HELD: begin
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= IDLE;
            level_out <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state == PRESS_WAIT) || (state == RELEASE_WAIT);

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse with STABLE_CYCLES=4 and a 10-unit clock.
module tb_button_debounce_pulse;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic level_out;
  logic pulse_out;
  logic busy;
  logic [2:0] tcount;

  int n_vec = 0;
  int n_err = 0;

  button_debounce_pulse #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .level_out (level_out),
    .pulse_out (pulse_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Downstream 3-bit counter enabled by pulse_out.
  always @(posedge clk or posedge reset) begin
    if (reset) tcount <= 3'd0;
    else if (pulse_out) tcount <= tcount + 3'd1;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit k of each pattern applies to edge k: b is btn_in sampled there, p/l/y are
  // the pulse_out/level_out/busy values expected just after that edge.
  task automatic seq(input string tag, input int n, input logic [31:0] b,
                     input logic [31:0] p, input logic [31:0] l, input logic [31:0] y);
    for (int k = 0; k < n; k++) begin
      btn_in = b[k];
      tick();
      chk($sformatf("%s[%0d].pulse", tag, k), {7'd0, pulse_out}, {7'd0, p[k]});
      chk($sformatf("%s[%0d].level", tag, k), {7'd0, level_out}, {7'd0, l[k]});
      chk($sformatf("%s[%0d].busy",  tag, k), {7'd0, busy},      {7'd0, y[k]});
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pulse"}, {7'd0, pulse_out}, 8'd0);
    chk({tag, ".level"}, {7'd0, level_out}, 8'd0);
    chk({tag, ".busy"},  {7'd0, busy},      8'd0);
    chk({tag, ".tcount"}, {5'd0, tcount},   8'd0);
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b1;
    #3;
    chk_all_zero("rst_hold_a");
    #4;
    chk_all_zero("rst_hold_b");
    #3;
    reset = 1'b0;

    // Button held through reset is a fresh press: pulse at E0+6.
    seq("rst_press", 10, 32'h3FF, 32'h40, 32'h3C0, 32'h3C);
    chk("rst_press.tcount", {5'd0, tcount}, 8'd1);

    seq("release1", 10, 32'h0, 32'h0, 32'h03F, 32'h3C);

    // Reset landing in the pulse cycle must kill outputs at once.
    seq("pulse_cut", 7, 32'h7F, 32'h40, 32'h40, 32'h3C);
    reset  = 1'b1;
    btn_in = 1'b0;
    #1;
    chk_all_zero("pulse_cut.rst");
    #2;
    reset = 1'b0;

    chk("clean.tcount0", {5'd0, tcount}, 8'd0);
    seq("clean", 20, 32'hFFFFF, 32'h40, 32'hFFFC0, 32'h3C);
    chk("clean.tcount1", {5'd0, tcount}, 8'd1);

    seq("glitch", 12, 32'hFFC, 32'h0, 32'hFFF, 32'h0C);
    seq("release2", 10, 32'h0, 32'h0, 32'h03F, 32'h3C);

    seq("bounce", 12, 32'h005, 32'h0, 32'h0, 32'h14);
    chk("bounce.tcount", {5'd0, tcount}, 8'd1);

    // Reset while PRESS_WAIT with cnt=2.
    seq("midpress", 5, 32'h1F, 32'h0, 32'h0, 32'h1C);
    reset  = 1'b1;
    btn_in = 1'b0;
    #1;
    chk_all_zero("midpress.rst");
    #2;
    reset = 1'b0;
    seq("midpress_after", 10, 32'h0, 32'h0, 32'h0, 32'h0);

    for (int i = 0; i < 8; i++) begin
      seq($sformatf("rep%0d.press", i), 8, 32'hFF, 32'h40, 32'hC0, 32'h3C);
      chk($sformatf("rep%0d.tcount", i), {5'd0, tcount}, 8'((i + 1) % 8));
      seq($sformatf("rep%0d.release", i), 8, 32'h0, 32'h0, 32'h3F, 32'h3C);
    end
    chk("rep.wrap", {5'd0, tcount}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/button_debounce_pulse.md
# button_debounce_pulse

Upstream conditioning stage for the 3-bit T flip-flop counter. It takes a raw, asynchronous, bouncing push-button level and produces two signals:
- a clean debounced level;
- a single-cycle `pulse_out` per accepted press, which drives the count-enable of the downstream T-counter stage.

The block consists of a two-flop synchronizer, a stability counter and a four-state FSM.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive synchronized-high/low cycles required to accept an edge.
  - Legal range ≥ 2.
  - Simulation uses 4; board builds override, e.g. 500000.
- `CNT_W`, default `$clog2(STABLE_CYCLES)` (minimum 1): stability counter width.

Ports:
- `clk`  in  1  system clock. One clock domain; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_in`  in  1  raw button level, asynchronous to `clk`, may bounce.
- `level_out`  out  1  debounced button level, registered.
- `pulse_out`  out  1  high for exactly one `clk` cycle per accepted press (rising edge only), registered.
- `busy`  out  1  high while the FSM is in PRESS_WAIT or RELEASE_WAIT, registered-state decode.

## Operation
- Synchronizer: `sync1 <= btn_in`, `btn_s <= sync1`. The FSM uses only `btn_s`.
- FSM states: IDLE (level 0), PRESS_WAIT, HELD (level 1), RELEASE_WAIT.
- IDLE:
  - `btn_s`=1 → PRESS_WAIT, `cnt`<=0.
  - Otherwise stay.
- PRESS_WAIT:
  - `btn_s`=0 → IDLE, `cnt`<=0. The bounce is rejected; no pulse.
  - `btn_s`=1 and `cnt`==STABLE_CYCLES-1 → HELD, `level_out`<=1, `pulse_out`<=1.
  - Otherwise `cnt`<=`cnt`+1.
- HELD:
  - `btn_s`=0 → RELEASE_WAIT, `cnt`<=0.
- RELEASE_WAIT:
  - `btn_s`=1 → HELD, `cnt`<=0. The glitch is rejected; `level_out` stays 1.
  - `btn_s`=0 and `cnt`==STABLE_CYCLES-1 → IDLE, `level_out`<=0.
  - Otherwise `cnt`++.
- `pulse_out` defaults to 0 on every edge unless set by the PRESS_WAIT→HELD transition. It is never high two consecutive cycles.
- Release produces no pulse.
- `cnt` never exceeds STABLE_CYCLES-1, so there is no wrap-around.

## Timing
- Reset (async assert): `sync1`, `btn_s`, `cnt`, `level_out`, `pulse_out` = 0; `busy` = 0; state = IDLE. Outputs drop immediately, including mid-HELD or mid-PRESS_WAIT.
- After reset deassertion, a button held through reset is treated as a new press and produces one pulse after the full latency.
- Press latency:
  - Let edge E0 be the first edge sampling `btn_in`=1.
  - `btn_s`=1 after E1.
  - FSM enters PRESS_WAIT at E2.
  - `pulse_out`/`level_out` rise after edge E0+2+STABLE_CYCLES (E6 for the default).
  - Condition: `btn_in` stays high through E0+STABLE_CYCLES.
- Release latency: symmetric. `level_out` falls after E0'+2+STABLE_CYCLES, where E0' is the first edge sampling `btn_in`=0.
- Minimum accepted press: `btn_s` high for STABLE_CYCLES+1 consecutive FSM edges.
- Downstream counter: sees `pulse_out` as a one-cycle enable and advances exactly once per accepted press.

## Structure
- Shared package `debounce_pkg`: state encoding localparams ST_IDLE=2'd0, ST_PRESS_WAIT=2'd1, ST_HELD=2'd2, ST_RELEASE_WAIT=2'd3. Reused by any later multi-button front-end.
- One sub-module: `sync_2ff`, a two-flop synchronizer with `clk`/`reset` and data in/out, reset value 0. The FSM, counter and output registers stay in `button_debounce_pulse`.

## Test plan
All scenarios use STABLE_CYCLES=4 and a 10-unit clock.
- Reset hold: `reset`=1 for 10 units with `btn_in`=1 → `level_out`=0, `pulse_out`=0, `busy`=0 throughout reset; after release, one pulse at E0+6.
- Clean press: `btn_in` 0→1 held for 20 cycles → `pulse_out`=1 for exactly one cycle at E0+6; `level_out`=1 from E0+6; downstream 3-bit counter goes 0→1.
- Bounce rejection: `btn_in` toggles 1,0,1,0 every cycle, then 0 → no `pulse_out`; `level_out` stays 0; `busy` is seen high then returns to 0.
- Release glitch: in HELD, `btn_in`=0 for 2 cycles then 1 → `level_out` stays 1, no pulse; a full release (0 for 10 cycles) drops `level_out` at E0'+6.
- Reset mid-press: assert `reset` while in PRESS_WAIT at `cnt`=2 → all outputs 0 immediately, state IDLE, no pulse after deassert if `btn_in`=0.
- Repeated presses: 8 clean presses → 8 single pulses; the downstream counter wraps 7→0.
